rd_ptr_empty_ctrl: RTL and testbench

//   Read-domain pointer and empty-flag generator for the async FIFO.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/gray2bin_conv.sv | 27 ++
 rtl/rd_ptr_empty_ctrl.sv | 120 ++++++++++++
 tb/tb_rd_ptr_empty_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO pointer blocks (read-side
//   rd_ptr_empty_ctrl and the write-side pointer/full block).
//   - ADDR_W : default RAM address width (depth = 2**ADDR_W)
//   - PTR_W  : pointer width, one extra bit to tell full from empty
//   - bin2gray / gray2bin : width-agnostic conversions on 32-bit values.
//     Callers zero-extend narrower pointers and truncate the result; both
//     conversions commute with that because every Gray/binary bit depends
//     only on bits at the same or higher positions.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDR_W = 7;
  localparam int PTR_W  = ADDR_W + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage : fifo_pkg

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
//   Combinational Gray-to-binary converter (XOR prefix from the MSB down).
//   Parameters:
//     W       : code width
//   Ports:
//     i_gray  : in  [W-1:0] Gray-coded value
//     o_bin   : out [W-1:0] binary equivalent
// -----------------------------------------------------------------------------
module gray2bin_conv #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the parity of all Gray bits at or above it; computing
  // each bit independently avoids a self-referencing combinational loop.
  always_comb begin
    // NOTE: combinational outputs get a full default first so no latch is inferred.
    o_bin = '0;
    for (int i = 0; i < W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule : gray2bin_conv

// File: rtl/rd_ptr_empty_ctrl.sv
// -----------------------------------------------------------------------------
// rd_ptr_empty_ctrl
//   Read-domain pointer and empty-flag generator for the async FIFO.
//   Takes the write pointer (Gray, already synchronised into rd_clk), advances
//   the read pointer on accepted reads, and produces registered empty, fill
//   level and a sticky underflow flag. All flags have one cycle of latency.
//
//   Optional feature macro: RD_ALMOST_EMPTY_EN
//     defined   -> adds parameter AE_THRESH and output rd_almost_empty
//     undefined -> neither exists; all other behaviour is identical
//
//   Parameters:
//     ADDR_W          RAM address width; pointers are ADDR_W+1 bits
//     AE_THRESH       almost-empty threshold in entries (RD_ALMOST_EMPTY_EN)
//   Ports:
//     rd_clk          in   read clock, everything on posedge
//     rd_rst          in   synchronous active-high reset
//     rq2_wrt_ptr     in   [ADDR_W:0] synchronised Gray write pointer
//     rd_en           in   read request
//     rd_addr         out  [ADDR_W-1:0] RAM read address
//     rd_ptr          out  [ADDR_W:0] registered Gray read pointer
//     rd_empty        out  registered empty flag
//     rd_level        out  [ADDR_W:0] registered entry count (pessimistic)
//     rd_underflow    out  sticky: read attempted while empty
//     rd_almost_empty out  level <= AE_THRESH (RD_ALMOST_EMPTY_EN)
// -----------------------------------------------------------------------------
module rd_ptr_empty_ctrl #(
  parameter int ADDR_W    = fifo_pkg::ADDR_W
`ifdef RD_ALMOST_EMPTY_EN
  ,
  parameter int AE_THRESH = 4
`endif
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic [ADDR_W:0]   rq2_wrt_ptr,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              rd_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_underflow
`ifdef RD_ALMOST_EMPTY_EN
  ,
  output logic              rd_almost_empty
`endif
);

  import fifo_pkg::bin2gray;

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] r_bin;
  logic [ADDR_W:0] r_ptr;
  logic            r_empty;
  logic [ADDR_W:0] r_level;
  logic            r_underflow;

  logic            w_inc;
  logic [ADDR_W:0] w_bin_next;
  logic [ADDR_W:0] w_gray_next;
  logic [ADDR_W:0] w_wb;
  logic [ADDR_W:0] w_level_next;

  gray2bin_conv #(
    .W (PW)
  ) u_wb_conv (
    .i_gray (rq2_wrt_ptr),
    .o_bin  (w_wb)
  );

  // A read is only accepted when the registered flag says data is present;
  // a refused read leaves the pointer untouched.
  assign w_inc        = rd_en & ~r_empty;
  assign w_bin_next   = r_bin + {{ADDR_W{1'b0}}, w_inc};
  assign w_gray_next  = PW'(bin2gray(32'(w_bin_next)));
  // Natural PW-bit wrap of the subtraction gives the count across MSB toggles.
  assign w_level_next = w_wb - w_bin_next;

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_bin       <= '0;
      r_ptr       <= '0;
      r_empty     <= 1'b1;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_bin       <= w_bin_next;
      r_ptr       <= w_gray_next;
      // Comparing the *next* pointer lets empty rise on the very edge that
      // consumes the last word, rather than one cycle later.
      r_empty     <= (w_gray_next == rq2_wrt_ptr);
      r_level     <= w_level_next;
      r_underflow <= r_underflow | (rd_en & r_empty);
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  logic r_almost_empty;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (32'(w_level_next) <= $unsigned(AE_THRESH));
    end
  end

  assign rd_almost_empty = r_almost_empty;
`endif

  assign rd_addr      = r_bin[ADDR_W-1:0];
  assign rd_ptr       = r_ptr;
  assign rd_empty     = r_empty;
  assign rd_level     = r_level;
  assign rd_underflow = r_underflow;

endmodule : rd_ptr_empty_ctrl

// File: tb/tb_rd_ptr_empty_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rd_ptr_empty_ctrl
//   Self-checking bench for rd_ptr_empty_ctrl with ADDR_W=3 (depth 8).
//   The reference model tracks plain integer counts of words written and
//   words read; expected pointers, address, level and flags are derived from
//   those counts. With RD_ALMOST_EMPTY_EN the bench uses AE_THRESH=2.
// -----------------------------------------------------------------------------
module tb_rd_ptr_empty_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AE_T  = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b0;
  logic [AW:0]   rq2_wrt_ptr = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr;
  logic          rd_empty;
  logic [AW:0]   rd_level;
  logic          rd_underflow;
`ifdef RD_ALMOST_EMPTY_EN
  logic          rd_almost_empty;
`endif

  rd_ptr_empty_ctrl #(
    .ADDR_W    (AW)
`ifdef RD_ALMOST_EMPTY_EN
    ,
    .AE_THRESH (AE_T)
`endif
  ) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .rq2_wrt_ptr     (rq2_wrt_ptr),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_ptr          (rd_ptr),
    .rd_empty        (rd_empty),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
`ifdef RD_ALMOST_EMPTY_EN
    ,
    .rd_almost_empty (rd_almost_empty)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: counts of words written (as seen through the
  // synchroniser) and words read, plus the two sticky/registered flags.
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = (AW + 1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl;
    lvl = wr_cnt - rd_cnt;
    check({tag, ":addr"},  32'(rd_addr),      32'(rd_cnt % DEPTH));
    check({tag, ":ptr"},   32'(rd_ptr),       32'(gray_of(rd_cnt)));
    check({tag, ":empty"}, 32'(rd_empty),     32'(m_empty));
    check({tag, ":level"}, 32'(rd_level),     32'(lvl));
    check({tag, ":uf"},    32'(rd_underflow), 32'(m_uf));
`ifdef RD_ALMOST_EMPTY_EN
    check({tag, ":ae"},    32'(rd_almost_empty), 32'(lvl <= AE_T));
`endif
  endtask

  // One clock: apply rd_en and `add` new writes, advance the model, check.
  task automatic step(input bit en, input int add, input string tag);
    rd_en       = en;
    wr_cnt      = wr_cnt + add;
    rq2_wrt_ptr = gray_of(wr_cnt);
    @(posedge rd_clk);
    m_uf = m_uf | (en & m_empty);
    if (en && !m_empty) rd_cnt++;
    m_empty = (wr_cnt == rd_cnt);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input bit en, input string tag);
    rd_rst = 1'b1;
    rd_en  = en;
    @(posedge rd_clk);
    rd_cnt  = 0;
    wr_cnt  = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    #1;
    rd_rst      = 1'b0;
    rd_en       = 1'b0;
    check_all(tag);
    rq2_wrt_ptr = '0;
  endtask

  initial begin
    // 1. Reset with write pointer at zero.
    rq2_wrt_ptr = '0;
    do_reset(1'b0, "reset");

    // 2. Three words arrive, then three reads drain them; empty rises on the
    //    edge consuming the last one.
    step(1'b0, 3, "fill3");
    check("fill3_level", 32'(rd_level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("drain_addr", 32'(rd_addr), 32'(i));
      step(1'b1, 0, "drain3");
    end
    check("drain3_empty", 32'(rd_empty), 32'd1);

    // 3. Read while empty: pointer holds, underflow sticks.
    step(1'b1, 0, "under");
    step(1'b0, 0, "under_hold");
    step(1'b0, 0, "under_hold2");

    // 4. Wrap: 20 full fill/drain rounds of 8 entries each.
    for (int r = 0; r < 20; r++) begin
      step(1'b0, DEPTH, "wrap_fill");
      for (int k = 0; k < DEPTH; k++) begin
        step(1'b1, 0, "wrap_drain");
      end
    end

    // 5. Randomised traffic; writes never exceed the free space.
    for (int n = 0; n < 400; n++) begin
      int room;
      int add;
      room = DEPTH - (wr_cnt - rd_cnt);
      add  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, room) : 0;
      step(1'(($urandom_range(0, 3) != 0) ? 1 : 0), add, "rand");
    end

    // 6. Reset mid-read at level 5, with rd_en held high through reset.
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (wr_cnt != rd_cnt) step(1'b1, 0, "pre_drain");
    end
    step(1'b0, 6, "pre_fill");
    step(1'b1, 0, "pre_read");
    check("pre_level5", 32'(rd_level), 32'd5);
    do_reset(1'b1, "mid_reset");
    step(1'b0, 0, "post_reset");
    step(1'b1, 2, "post_reset_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rd_ptr_empty_ctrl
